// File: rtl/main_slave_loader_pkg.sv
// Shared types and constants for the main_slave_loader harness stage.
//   state_e : sequencer states (load, run, dump)
//   SZ_BYTE : slave access size for a single byte, in bits
//   SZ_WORD : slave access size for a 32-bit word, in bits
package main_slave_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadCollect,
    StLoadWrite,
    StStart,
    StRun,
    StDumpReq,
    StDumpOut,
    StDone
  } state_e;

  localparam int unsigned SZ_BYTE = 8;
  localparam int unsigned SZ_WORD = 32;

endpackage

// File: rtl/main_loader_byte_packer.sv
// Packs incoming bytes little-endian into a 32-bit word and tracks how many are valid.
// Tail bytes are drained one at a time by pop, which shifts the word down a byte.
//   clock, reset : clock and synchronous active-high reset
//   clear        : drop all held bytes
//   push         : append push_byte at the next free byte lane (ignored when full)
//   pop          : discard byte lane 0 and shift the rest down
//   word, count  : packed word and number of valid bytes (0..4)
module main_loader_byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  push_byte,
  input  logic        pop,
  output logic [31:0] word,
  output logic [2:0]  count
);

  logic [31:0] word_q, word_d;
  logic [2:0]  count_q, count_d;

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear) begin
      word_d  = '0;
      count_d = '0;
    end else if (pop) begin
      word_d  = {8'h00, word_q[31:8]};
      count_d = count_q - 3'd1;
    end else if (push && (count_q < 3'd4)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (count_q[1:0] == 2'(i)) begin
          word_d[8*i +: 8] = push_byte;
        end
      end
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign word  = word_q;
  assign count = count_q;

endmodule

// File: rtl/main_slave_loader.sv
// Harness stage around the HLS `main` accelerator: loads a byte stream into its memory over
// slave channel 0, pulses start_port, counts cycles until done_port, then streams the result
// region back out as 32-bit little-endian words.
//   clock, reset              : clock, synchronous active-high reset
//   cfg_base/cfg_len/cfg_go   : region byte base, byte length, start request (sampled in idle)
//   in_data/in_valid/in_ready : load byte stream
//   out_data/out_valid/out_ready : dumped word stream
//   start_port/done_port      : run handshake with `main`
//   S_*/Sout_*                : two-channel slave memory port; channel 1 is tied off
//   busy, cycles, err_timeout : status (run length, sticky abort flag)
module main_slave_loader
  import main_slave_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SIZE_W  = 7,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W:0]       cfg_len,
  input  logic                  cfg_go,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  busy,
  output logic [31:0]           cycles,
  output logic                  err_timeout
);

  localparam logic [31:0] TimeoutC = 32'(TIMEOUT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     off_q, off_d;
  logic [31:0]         cycles_q, cycles_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                pk_clear, pk_push, pk_pop;
  logic [31:0]         pk_word;
  logic [2:0]          pk_count;

  logic                oe0, we0;
  logic [ADDR_W-1:0]   addr0;
  logic [DATA_W-1:0]   wdata0;
  logic [SIZE_W-1:0]   size0;

  logic [ADDR_W:0]     remaining;
  logic [2:0]          need;
  logic [ADDR_W+1:0]   off_plus4;
  logic                last_word;
  logic                unused_inputs;

  main_loader_byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (pk_clear),
    .push      (pk_push),
    .push_byte (in_data),
    .pop       (pk_pop),
    .word      (pk_word),
    .count     (pk_count)
  );

  // Bytes still to load for the word being collected; offset only moves on completed writes.
  assign remaining = len_q - off_q;
  assign need      = (remaining >= (ADDR_W+1)'(4)) ? 3'd4 : remaining[2:0];
  // One extra bit so the last-word test cannot wrap near the top of the length range.
  assign off_plus4 = {1'b0, off_q} + (ADDR_W+2)'(4);
  assign last_word = off_plus4 >= {1'b0, len_q};

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    off_d      = off_q;
    cycles_d   = cycles_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    pk_pop     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    start_port = 1'b0;
    oe0        = 1'b0;
    we0        = 1'b0;
    addr0      = '0;
    wdata0     = '0;
    size0      = '0;

    case (state_q)
      StIdle: begin
        if (cfg_go) begin
          base_d   = cfg_base;
          len_d    = cfg_len;
          off_d    = '0;
          cycles_d = '0;
          err_d    = 1'b0;
          pk_clear = 1'b1;
          state_d  = (cfg_len == '0) ? StStart : StLoadCollect;
        end
      end

      StLoadCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pk_push = 1'b1;
          if ((pk_count + 3'd1) == need) begin
            state_d = StLoadWrite;
          end
        end
      end

      StLoadWrite: begin
        we0   = 1'b1;
        addr0 = base_q + off_q[ADDR_W-1:0];
        // A full word goes out as one access; a short tail drains one byte per access.
        if (pk_count == 3'd4) begin
          wdata0 = DATA_W'(pk_word);
          size0  = SIZE_W'(SZ_WORD);
        end else begin
          wdata0 = DATA_W'(pk_word[7:0]);
          size0  = SIZE_W'(SZ_BYTE);
        end
        if (Sout_DataRdy[0]) begin
          if (pk_count == 3'd4) begin
            off_d    = off_q + (ADDR_W+1)'(4);
            pk_clear = 1'b1;
          end else begin
            off_d  = off_q + (ADDR_W+1)'(1);
            pk_pop = 1'b1;
          end
          if (off_d == len_q) begin
            state_d = StStart;
          end else if (pk_count == 3'd4) begin
            state_d = StLoadCollect;
          end
        end
      end

      StStart: begin
        start_port = 1'b1;
        cycles_d   = 32'd1;  // the start cycle itself counts
        off_d      = '0;
        state_d    = StRun;
      end

      StRun: begin
        if (done_port) begin
          state_d = (len_q == '0) ? StDone : StDumpReq;
        end else if (cycles_q >= (TimeoutC - 32'd1)) begin
          cycles_d = TimeoutC;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cycles_d = cycles_q + 32'd1;
        end
      end

      StDumpReq: begin
        oe0   = 1'b1;
        addr0 = base_q + off_q[ADDR_W-1:0];
        size0 = SIZE_W'(SZ_WORD);
        if (Sout_DataRdy[0]) begin
          rdata_d = Sout_Rdata_ram[31:0];
          state_d = StDumpOut;
        end
      end

      StDumpOut: begin
        out_valid = 1'b1;
        out_data  = rdata_q;
        if (out_ready) begin
          off_d   = off_plus4[ADDR_W:0];
          state_d = last_word ? StDone : StDumpReq;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      off_q    <= '0;
      cycles_q <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      off_q    <= off_d;
      cycles_q <= cycles_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign S_oe_ram        = {1'b0, oe0};
  assign S_we_ram        = {1'b0, we0};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr0};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata0};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size0};

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign cycles      = cycles_q;
  assign err_timeout = err_q;

  // Channel 1 and the upper read lanes carry nothing this stage needs.
  assign unused_inputs = ^{Sout_DataRdy[1], Sout_Rdata_ram[2*DATA_W-1:32]};

endmodule

// File: tb/tb_main_slave_loader.sv
module tb_main_slave_loader;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 7;
  localparam int unsigned TO = 50;
  localparam int DONE_DLY = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] cfg_base = '0;
  logic [AW:0] cfg_len = '0;
  logic cfg_go = 1'b0;
  logic [7:0] in_data;
  logic in_valid, in_ready;
  logic [31:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic start_port, done_port;
  logic [1:0] S_oe_ram, S_we_ram;
  logic [2*AW-1:0] S_addr_ram;
  logic [2*DW-1:0] S_Wdata_ram;
  logic [2*SW-1:0] S_data_ram_size;
  logic [2*DW-1:0] Sout_Rdata_ram;
  logic [1:0] Sout_DataRdy;
  logic busy;
  logic [31:0] cycles;
  logic err_timeout;

  main_slave_loader #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SIZE_W (SW),
    .TIMEOUT(TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_base       (cfg_base),
    .cfg_len        (cfg_len),
    .cfg_go         (cfg_go),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .start_port     (start_port),
    .done_port      (done_port),
    .S_oe_ram       (S_oe_ram),
    .S_we_ram       (S_we_ram),
    .S_addr_ram     (S_addr_ram),
    .S_Wdata_ram    (S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram (Sout_Rdata_ram),
    .Sout_DataRdy   (Sout_DataRdy),
    .busy           (busy),
    .cycles         (cycles),
    .err_timeout    (err_timeout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory model with programmable response latency.
  logic [7:0] mem [512];
  logic [7:0] exp_mem [512];
  logic mem_ready = 1'b0;
  int mem_delay = 0;
  int wcnt = 0;
  logic [AW-1:0] a0, a1, a2, a3;
  assign a0 = S_addr_ram[AW-1:0];
  assign a1 = a0 + 9'd1;
  assign a2 = a0 + 9'd2;
  assign a3 = a0 + 9'd3;
  assign Sout_DataRdy = {1'b0, ((S_oe_ram[0] | S_we_ram[0]) && (wcnt == mem_delay))};
  assign Sout_Rdata_ram = {64'h0, 32'hDEAD_BEEF, mem[a3], mem[a2], mem[a1], mem[a0]};

  // Byte source.
  logic [7:0] src_bytes [64];
  int src_len = 0;
  int src_off = 0;
  int acc_cnt = 0;
  int src_pos;
  assign src_pos  = acc_cnt - src_off;
  assign in_valid = (src_pos < src_len);
  assign in_data  = src_bytes[src_pos[5:0]];

  // `main` model: done_port rises DONE_DLY cycles after the start_port cycle.
  logic done_en = 1'b1;
  logic armed = 1'b0;
  int run_cnt = 0;
  assign done_port = armed && done_en && (run_cnt >= DONE_DLY);

  // Values captured mid-cycle, consumed at the next rising edge.
  logic en_s = 1'b0, rdy_s = 1'b0, start_s = 1'b0, acc_s = 1'b0;
  logic pend = 1'b0, opend = 1'b0;
  logic [83:0] prev_acc = '0;
  logic [31:0] prev_out = '0;
  int stab_bad = 0, ostab_bad = 0, both_bad = 0, ch1_bad = 0, rd_n = 0, start_total = 0;
  int wr_a[$];
  logic [31:0] wr_d[$];
  int wr_s[$];
  logic [31:0] out_q[$];
  logic [83:0] cur_acc;
  assign cur_acc = {S_oe_ram, S_we_ram, S_addr_ram[AW-1:0], S_Wdata_ram[DW-1:0],
                    S_data_ram_size[SW-1:0]};

  always @(negedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_ready <= 1'b1;
    end
    en_s    <= S_oe_ram[0] | S_we_ram[0];
    rdy_s   <= Sout_DataRdy[0];
    start_s <= start_port && !reset;
    acc_s   <= in_valid && in_ready && !reset;
    if (reset) begin
      pend  <= 1'b0;
      opend <= 1'b0;
    end else begin
      if (S_oe_ram[0] && S_we_ram[0]) both_bad <= both_bad + 1;
      if (S_oe_ram[1] || S_we_ram[1] || (S_addr_ram[2*AW-1:AW] != '0) ||
          (S_Wdata_ram[2*DW-1:DW] != '0) || (S_data_ram_size[2*SW-1:SW] != '0))
        ch1_bad <= ch1_bad + 1;
      if (pend && (cur_acc != prev_acc)) stab_bad <= stab_bad + 1;
      pend     <= (S_oe_ram[0] | S_we_ram[0]) && !Sout_DataRdy[0];
      prev_acc <= cur_acc;
      if (opend && (!out_valid || (out_data != prev_out))) ostab_bad <= ostab_bad + 1;
      opend    <= out_valid && !out_ready;
      prev_out <= out_data;
      if (out_valid && out_ready) out_q.push_back(out_data);
      if (start_port) start_total <= start_total + 1;
      if ((S_oe_ram[0] | S_we_ram[0]) && Sout_DataRdy[0]) begin
        if (S_we_ram[0]) begin
          wr_a.push_back(int'(a0));
          wr_d.push_back(S_Wdata_ram[31:0]);
          wr_s.push_back(int'(S_data_ram_size[SW-1:0]));
          mem[a0] <= S_Wdata_ram[7:0];
          if (S_data_ram_size[SW-1:0] == 7'd32) begin
            mem[a1] <= S_Wdata_ram[15:8];
            mem[a2] <= S_Wdata_ram[23:16];
            mem[a3] <= S_Wdata_ram[31:24];
          end
        end else begin
          rd_n <= rd_n + 1;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      wcnt    <= 0;
      armed   <= 1'b0;
      run_cnt <= 0;
    end else begin
      if (en_s) wcnt <= rdy_s ? 0 : wcnt + 1;
      else wcnt <= 0;
      if (start_s) begin
        armed   <= 1'b1;
        run_cnt <= 1;
      end else if (armed) begin
        run_cnt <= run_cnt + 1;
      end
      if (acc_s) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_start"}, 64'(start_port), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cycles"}, 64'(cycles), 64'd0);
    check({tag, "_err"}, 64'(err_timeout), 64'd0);
    check({tag, "_slave"}, 64'({S_oe_ram, S_we_ram, |S_addr_ram, |S_Wdata_ram,
                                |S_data_ram_size}), 64'd0);
  endtask

  typedef struct {
    int          base;
    int          len;
    int          delay;
    int          stall;
    logic        done_en;
    int          seed;
    logic [31:0] first_wr;
    int          exp_cycles;
    logic        exp_err;
    int          exp_nout;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int w0, r0, o0, s0, nw, n, scnt, aw, ao;
    int ea[64];
    int es[64];
    logic [31:0] ed[64];
    logic [7:0] b[64];
    logic [31:0] ew;
    int a;
    // Reference: writes, post-load memory image and expected dump words.
    for (int i = 0; i < 64; i++) begin
      b[i] = 8'(v.seed + i);
      src_bytes[i] = b[i];
    end
    nw = 0;
    for (int o = 0; o + 4 <= v.len; o += 4) begin
      ea[nw] = (v.base + o) % 512;
      ed[nw] = {b[o+3], b[o+2], b[o+1], b[o]};
      es[nw] = 32;
      nw++;
    end
    for (int o = (v.len / 4) * 4; o < v.len; o++) begin
      ea[nw] = (v.base + o) % 512;
      ed[nw] = {24'h0, b[o]};
      es[nw] = 8;
      nw++;
    end
    for (int o = 0; o < v.len; o++) exp_mem[(v.base + o) % 512] = b[o];

    w0 = wr_a.size();
    o0 = out_q.size();
    r0 = rd_n;
    s0 = start_total;
    mem_delay = v.delay;
    done_en   = v.done_en;
    src_len   = v.len;
    src_off   = acc_cnt;

    cfg_base = AW'(v.base);
    cfg_len  = (AW+1)'(v.len);
    cfg_go   = 1'b1;
    tick();
    cfg_go = 1'b0;
    check($sformatf("v%0d_busy_after_go", idx), 64'(busy), 64'd1);
    // A request while busy must not disturb the sequence in flight.
    cfg_base = AW'(0);
    cfg_len  = (AW+1)'(3);
    cfg_go   = 1'b1;
    tick();
    cfg_go = 1'b0;

    n = 0;
    scnt = 0;
    while (busy && n < 2000) begin
      if (out_valid && scnt < v.stall) begin
        out_ready = 1'b0;
        scnt++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) scnt = 0;
      end
      tick();
      n++;
    end
    out_ready = 1'b1;
    check($sformatf("v%0d_completes", idx), 64'(busy), 64'd0);
    check($sformatf("v%0d_cycles", idx), 64'(cycles), 64'(v.exp_cycles));
    check($sformatf("v%0d_err_timeout", idx), 64'(err_timeout), 64'(v.exp_err));

    aw = wr_a.size() - w0;
    check($sformatf("v%0d_write_count", idx), 64'(aw), 64'(nw));
    for (int i = 0; i < nw && i < aw; i++) begin
      check($sformatf("v%0d_wr%0d_addr", idx, i), 64'(wr_a[w0+i]), 64'(ea[i]));
      check($sformatf("v%0d_wr%0d_data", idx, i), 64'(wr_d[w0+i]), 64'(ed[i]));
      check($sformatf("v%0d_wr%0d_size", idx, i), 64'(wr_s[w0+i]), 64'(es[i]));
    end
    if (aw > 0) check($sformatf("v%0d_first_write", idx), 64'(wr_d[w0]), 64'(v.first_wr));

    check($sformatf("v%0d_read_count", idx), 64'(rd_n - r0), 64'(v.exp_nout));
    ao = out_q.size() - o0;
    check($sformatf("v%0d_out_count", idx), 64'(ao), 64'(v.exp_nout));
    for (int k = 0; k < ao && k < v.exp_nout; k++) begin
      a  = (v.base + 4 * k) % 512;
      ew = {exp_mem[(a+3)%512], exp_mem[(a+2)%512], exp_mem[(a+1)%512], exp_mem[a]};
      check($sformatf("v%0d_out%0d", idx, k), 64'(out_q[o0+k]), 64'(ew));
    end
    check($sformatf("v%0d_start_pulses", idx), 64'(start_total - s0), 64'd1);
    check($sformatf("v%0d_slave_stable", idx), 64'(stab_bad), 64'd0);
    check($sformatf("v%0d_out_stable", idx), 64'(ostab_bad), 64'd0);
    check($sformatf("v%0d_oe_we_exclusive", idx), 64'(both_bad), 64'd0);
    check($sformatf("v%0d_ch1_tied", idx), 64'(ch1_bad), 64'd0);
    tick();
  endtask

  vec_t vecs[8];
  int n;

  initial begin
    //          base len dly stall done seed  first_wr      cyc err nout
    vecs[0] = '{128, 8, 0, 0, 1'b1, 8'h01, 32'h0403_0201, 5,  1'b0, 2};
    vecs[1] = '{128, 6, 0, 0, 1'b1, 8'h11, 32'h1413_1211, 5,  1'b0, 2};
    vecs[2] = '{200, 5, 3, 4, 1'b1, 8'h40, 32'h4342_4140, 5,  1'b0, 2};
    vecs[3] = '{64,  3, 1, 0, 1'b1, 8'h70, 32'h0000_0070, 5,  1'b0, 1};
    vecs[4] = '{300, 4, 0, 2, 1'b1, 8'hA0, 32'hA3A2_A1A0, 5,  1'b0, 1};
    vecs[5] = '{16,  4, 0, 0, 1'b0, 8'h20, 32'h2322_2120, 50, 1'b1, 0};
    vecs[6] = '{0,   0, 0, 0, 1'b1, 8'h00, 32'h0000_0000, 5,  1'b0, 0};
    vecs[7] = '{400, 8, 0, 0, 1'b1, 8'h81, 32'h8483_8281, 5,  1'b0, 2};
    for (int i = 0; i < 512; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 64; i++) src_bytes[i] = 8'h00;

    reset = 1'b1;
    tick();
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("idle");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a load: only three of eight bytes are offered.
    for (int i = 0; i < 64; i++) src_bytes[i] = 8'(8'h90 + i);
    done_en   = 1'b1;
    mem_delay = 0;
    src_len   = 3;
    src_off   = acc_cnt;
    cfg_base  = AW'(400);
    cfg_len   = (AW+1)'(8);
    cfg_go    = 1'b1;
    tick();
    cfg_go = 1'b0;
    n = 0;
    while ((acc_cnt - src_off) < 3 && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("midload_bytes_taken", 64'(acc_cnt - src_off), 64'd3);
    check("midload_still_collecting", 64'(in_ready), 64'd1);
    reset = 1'b1;
    tick();
    check_zero("midload_reset");
    reset = 1'b0;
    tick();
    run_vec(7, vecs[7]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
